// File: rtl/mem_controller.sv
// Direct-mapped line cache controller with miss/repair handshake.
// Misses are reported to the arbiter, filled externally, then replayed.
module mem_controller #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         raddr_valid,
    input  logic [31:0]  raddr,
    input  logic         waddr_valid,
    input  logic [31:0]  waddr,
    input  logic [255:0] wdata,
    input  logic [31:0]  wmask,
    input  logic         repair_resolved,
    output logic [31:0]  rdata,
    output logic         rdata_valid,
    output logic         read_miss_repair,
    output logic         write_miss_repair,
    output logic [31:0]  missed_addr
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        MISS   = 2'd2,
        REPLAY = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [255:0]         data_q [NUM_LINES];

    logic                 req_wr_q;
    logic [31:0]          req_addr_q;
    logic [255:0]         req_wdata_q;
    logic [31:0]          req_wmask_q;

    logic [31:0]          lk_addr;
    logic [IDX_W-1:0]     lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic                 lk_hit;
    logic [IDX_W-1:0]     req_idx;
    logic [255:0]         req_line;
    logic [31:0]          req_word;

    logic                 idle_rd;
    logic                 idle_wr;
    logic                 fill;
    logic                 replay_wr_hit;

    // Byte-enable merge of new data into an existing line
    function automatic logic [255:0] merge(
        input logic [255:0] old_line,
        input logic [255:0] new_line,
        input logic [31:0]  mask
    );
        logic [255:0] r;
        r = old_line;
        for (int i = 0; i < 32; i++) begin
            if (mask[i]) r[i*8 +: 8] = new_line[i*8 +: 8];
        end
        return r;
    endfunction

    // Lookup address: the replayed request in REPLAY, else the incoming one
    always_comb begin
        lk_addr = raddr_valid ? raddr : waddr;
        if (state_q == REPLAY) lk_addr = req_addr_q;
    end

    assign lk_idx   = lk_addr[5 +: IDX_W];
    assign lk_tag   = lk_addr[31 -: TAG_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign req_idx  = req_addr_q[5 +: IDX_W];
    assign req_line = data_q[req_idx];
    assign req_word = req_line[{req_addr_q[4:2], 5'b0} +: 32];

    assign idle_rd       = (state_q == IDLE) && raddr_valid;
    assign idle_wr       = (state_q == IDLE) && waddr_valid && !raddr_valid;
    assign fill          = (state_q == MISS) && waddr_valid
                           && (waddr[31:5] == req_addr_q[31:5]);
    assign replay_wr_hit = (state_q == REPLAY) && req_wr_q && lk_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (raddr_valid)      state_d = lk_hit ? RESP : MISS;
                else if (waddr_valid) state_d = lk_hit ? IDLE : MISS;
            end
            RESP:   state_d = IDLE;
            MISS:   if (repair_resolved) state_d = REPLAY;
            REPLAY: state_d = lk_hit ? IDLE : MISS;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and latched request
    always_comb begin
        rdata             = '0;
        rdata_valid       = 1'b0;
        read_miss_repair  = 1'b0;
        write_miss_repair = 1'b0;
        missed_addr       = '0;
        case (state_q)
            RESP: begin
                rdata_valid = 1'b1;
                rdata       = req_word;
            end
            MISS: begin
                read_miss_repair  = !req_wr_q;
                write_miss_repair = req_wr_q;
                missed_addr       = {req_addr_q[31:5], 5'b0};
            end
            REPLAY: begin
                if (!req_wr_q && lk_hit) begin
                    rdata_valid = 1'b1;
                    rdata       = req_word;
                end
            end
            default: ;
        endcase
    end

    // Latch the request accepted in IDLE for response, miss and replay
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
        end else if (idle_rd) begin
            req_wr_q   <= 1'b0;
            req_addr_q <= raddr;
        end else if (idle_wr) begin
            req_wr_q    <= 1'b1;
            req_addr_q  <= waddr;
            req_wdata_q <= wdata;
            req_wmask_q <= wmask;
        end
    end

    // Line valid bits
    always_ff @(posedge clk) begin
        if (rst)       valid_q <= '0;
        else if (fill) valid_q[req_idx] <= 1'b1;
    end

    // Line data and tags: write hits, fills and replayed writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (idle_wr && lk_hit) begin
                data_q[lk_idx] <= merge(data_q[lk_idx], wdata, wmask);
            end else if (fill) begin
                data_q[req_idx] <= merge(data_q[req_idx], wdata, wmask);
                tag_q[req_idx]  <= req_addr_q[31 -: TAG_W];
            end else if (replay_wr_hit) begin
                data_q[req_idx] <= merge(data_q[req_idx], req_wdata_q,
                                         req_wmask_q);
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lk_addr[4:0], req_addr_q[1:0]};

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: transaction model + scoreboard.
// Read responses are queued with their expected cycle and checked by a monitor.
module tb_mem_controller;

    localparam int NL = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         raddr_valid;
    logic [31:0]  raddr;
    logic         waddr_valid;
    logic [31:0]  waddr;
    logic [255:0] wdata;
    logic [31:0]  wmask;
    logic         repair_resolved;
    logic [31:0]  rdata;
    logic         rdata_valid;
    logic         read_miss_repair;
    logic         write_miss_repair;
    logic [31:0]  missed_addr;

    mem_controller #(.NUM_LINES(NL)) dut (
        .clk               (clk),
        .rst               (rst),
        .raddr_valid       (raddr_valid),
        .raddr             (raddr),
        .waddr_valid       (waddr_valid),
        .waddr             (waddr),
        .wdata             (wdata),
        .wmask             (wmask),
        .repair_resolved   (repair_resolved),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .read_miss_repair  (read_miss_repair),
        .write_miss_repair (write_miss_repair),
        .missed_addr       (missed_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: per-slot line address, valid, and byte contents
    logic [7:0]  m_b    [NL][32];
    bit          m_v    [NL];
    logic [26:0] m_ln   [NL];
    bit          m_init [NL];

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic int slot(logic [31:0] a);
        return int'((a >> 5) % NL);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        int s = slot(a);
        return m_v[s] && (m_ln[s] == a[31:5]);
    endfunction

    function automatic logic [31:0] m_word(logic [31:0] a);
        int s = slot(a);
        int w = int'(a[4:2]);
        return {m_b[s][4*w+3], m_b[s][4*w+2], m_b[s][4*w+1], m_b[s][4*w]};
    endfunction

    function automatic void m_merge(int s, logic [255:0] d, logic [31:0] m);
        for (int i = 0; i < 32; i++) begin
            if (m[i]) m_b[s][i] = d[i*8 +: 8];
        end
    endfunction

    function automatic void m_fill(logic [31:0] a, logic [255:0] d,
                                   logic [31:0] m);
        int s = slot(a);
        m_merge(s, d, m);
        m_v[s]  = 1'b1;
        m_ln[s] = a[31:5];
        if (m == 32'hFFFF_FFFF) m_init[s] = 1'b1;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: every rdata_valid must match the head of the queue
    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rdata: got %h with no request",
                         rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", rdata, e.data);
                chk("rdata_latency", cyc, e.at);
            end
        end else begin
            chk("rdata_idle_zero", rdata, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        raddr_valid     = 1'b0;
        raddr           = '0;
        waddr_valid     = 1'b0;
        waddr           = '0;
        wdata           = '0;
        wmask           = '0;
        repair_resolved = 1'b0;
    endtask

    task automatic chk_flags(string nm, bit rf, bit wf, logic [31:0] ma);
        chk({nm, "_rflag"}, 32'(read_miss_repair), 32'(rf));
        chk({nm, "_wflag"}, 32'(write_miss_repair), 32'(wf));
        chk({nm, "_maddr"}, missed_addr, ma);
    endtask

    // One read or write transaction, including miss repair when needed.
    // mode 1: resolve once without a fill first; mode 2: wrong-line fill first
    task automatic access(input bit wr, input logic [31:0] a,
                          input logic [255:0] wd, input logic [31:0] wm,
                          input logic [255:0] fd, input logic [31:0] fm,
                          input int mode);
        logic [31:0] la;
        bit split;
        la = {a[31:5], 5'b0};
        raddr_valid = !wr;
        raddr       = a;
        waddr_valid = wr;
        waddr       = a;
        wdata       = wd;
        wmask       = wm;
        if (m_hit(a)) begin
            tick();
            idle_in();
            chk_flags("hit", 1'b0, 1'b0, 32'h0);
            if (wr) begin
                m_merge(slot(a), wd, wm);
            end else begin
                exp_q.push_back('{m_word(a), cyc});
                waddr_valid = 1'b1;
                waddr       = la;
                wdata       = rnd256();
                wmask       = 32'hFFFF_FFFF;
                tick();
                idle_in();
            end
        end else begin
            tick();
            idle_in();
            chk_flags("miss", !wr, wr, la);
            repeat ($urandom_range(0, 2)) begin
                repair_resolved = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b0;
                tick();
                chk_flags("miss_hold", !wr, wr, la);
            end
            if (mode == 2) begin
                waddr_valid = 1'b1;
                waddr       = la ^ 32'h0000_0100;
                wdata       = rnd256();
                wmask       = 32'hFFFF_FFFF;
                tick();
                idle_in();
                chk_flags("wrong_fill", !wr, wr, la);
            end
            if (mode == 1) begin
                repair_resolved = 1'b1;
                tick();
                idle_in();
                chk_flags("replay_nofill", 1'b0, 1'b0, 32'h0);
                tick();
                chk_flags("reraise", !wr, wr, la);
            end
            split = $urandom_range(0, 1) == 1;
            waddr_valid = 1'b1;
            waddr       = la | 32'($urandom_range(0, 31));
            wdata       = fd;
            wmask       = fm;
            if (split) begin
                tick();
                idle_in();
                m_fill(a, fd, fm);
                chk_flags("after_fill", !wr, wr, la);
            end
            repair_resolved = 1'b1;
            tick();
            idle_in();
            if (!split) m_fill(a, fd, fm);
            chk_flags("replay", 1'b0, 1'b0, 32'h0);
            if (wr) m_merge(slot(a), wd, wm);
            else    exp_q.push_back('{m_word(a), cyc});
            tick();
            chk_flags("back_idle", 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        repeat (2) tick();
        for (int s = 0; s < NL; s++) m_v[s] = 1'b0;
        chk("reset_rvalid", 32'(rdata_valid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk_flags("reset", 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] fill_mask(logic [31:0] a);
        return m_init[slot(a)] ? $urandom : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [255:0] fd;
        logic [255:0] wd;
        logic [31:0]  a;
        bit           wr;
        for (int s = 0; s < NL; s++) begin
            m_v[s]    = 1'b0;
            m_init[s] = 1'b0;
            m_ln[s]   = '0;
            for (int i = 0; i < 32; i++) m_b[s][i] = 8'h0;
        end
        do_reset();

        // Cold read miss, fill with 0xDEADBEEF in word 1, replayed response
        fd = rnd256();
        fd[63:32] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_1004, '0, '0, fd, 32'hFFFF_FFFF, 0);
        // Warm hit
        access(1'b0, 32'h0000_1004, '0, '0, '0, '0, 0);
        // Partial write hit on word 1, then read words back
        wd = '0;
        wd[63:32] = 32'h1234_5678;
        access(1'b1, 32'h0000_1000, wd, 32'h0000_00F0, '0, '0, 0);
        for (int w = 0; w < 8; w++) begin
            access(1'b0, 32'h0000_1000 + 32'(w * 4), '0, '0, '0, '0, 0);
        end
        // Conflict write miss, resolve without fill first, pending merge
        access(1'b1, 32'h0000_2000, rnd256(), $urandom, rnd256(),
               32'hFFFF_FFFF, 1);
        access(1'b0, 32'h0000_2008, '0, '0, '0, '0, 0);
        // Old line evicted: read misses, wrong-line fill ignored first
        access(1'b0, 32'h0000_1004, '0, '0, rnd256(), 32'hFFFF_FFFF, 2);

        // Simultaneous read and write to a hit line: only the read happens
        raddr_valid = 1'b1;
        raddr       = 32'h0000_1004;
        waddr_valid = 1'b1;
        waddr       = 32'h0000_1000;
        wdata       = rnd256();
        wmask       = 32'hFFFF_FFFF;
        tick();
        idle_in();
        exp_q.push_back('{m_word(32'h0000_1004), cyc});
        chk_flags("both", 1'b0, 1'b0, 32'h0);
        tick();
        for (int w = 0; w < 8; w++) begin
            access(1'b0, 32'h0000_1000 + 32'(w * 4), '0, '0, '0, '0, 0);
        end

        // Reset in the middle of a miss abandons the request
        raddr_valid = 1'b1;
        raddr       = 32'h0000_7F04;
        tick();
        idle_in();
        chk_flags("pre_rst", 1'b1, 1'b0, 32'h0000_7F00);
        do_reset();
        repeat (3) begin
            tick();
            chk_flags("post_rst", 1'b0, 1'b0, 32'h0);
        end

        // Randomized traffic over a small address space
        for (int n = 0; n < 300; n++) begin
            a  = (32'($urandom_range(0, 3)) << 8)
               | (32'($urandom_range(0, 7)) << 5)
               | 32'($urandom_range(0, 31));
            wr = $urandom_range(0, 1) == 1;
            if (wr && !m_hit(a) && !m_init[slot(a)]) wr = 1'b0;
            access(wr, a, rnd256(), $urandom, rnd256(), fill_mask(a),
                   int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) begin
                repair_resolved = 1'b1;
                tick();
                idle_in();
                chk_flags("stray_resolve", 1'b0, 1'b0, 32'h0);
            end
        end

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
